// File: rtl/chan_serializer_8.sv
// Eight-channel frame serializer: queues 192-bit frames of 24-bit samples and
// emits them one channel at a time as rounded, saturated 16-bit samples.
module chan_serializer_8 #(
  parameter int SHIFT      = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         c,
  input  logic         reset,
  input  logic [191:0] id,
  input  logic         iv,
  output logic [15:0]  od,
  output logic [2:0]   och,
  output logic         ov,
  input  logic         ordy,
  output logic         ovf,
  output logic         sat
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, SEND} state_t;

  // Returns {clipped, sample}: scale, round half up, arithmetic shift, clamp.
  function automatic logic [16:0] conv(input logic [23:0] x);
    logic signed [31:0] t;
    logic signed [31:0] r;
    logic signed [31:0] y;
    logic [16:0]        res;
    t = {{8{x[23]}}, x};
    t = t <<< SHIFT;
    r = t + 32'sd128;
    y = r >>> 8;
    if (y > 32'sd32767) begin
      res = {1'b1, 16'h7FFF};
    end else if (y < -32'sd32768) begin
      res = {1'b1, 16'h8000};
    end else begin
      res = {1'b0, y[15:0]};
    end
    return res;
  endfunction

  logic [191:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            empty, full, push, pop;
  logic [191:0]    head;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [2:0]      cnt_inc;
  logic [191:0]    frame_reg, frame_next;
  logic [15:0]     od_reg, od_next;
  logic [2:0]      och_reg, och_next;
  logic            ov_reg, ov_next;
  logic            clip_reg, clip_next;
  logic            ovf_reg, ovf_next;
  logic            sat_reg, sat_next;
  logic            xfer;
  logic [16:0]     head_conv, step_conv;
  logic [23:0]     frame_ch [8];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {DEPTH_LOG2{1'b0}}});
  // A frame arriving while full is lost even if a pop frees a slot this cycle.
  assign push  = iv & ~full;
  assign head  = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  always_ff @(posedge c) begin
    if (push) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= id;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      assign frame_ch[gi] = frame_reg[24*gi +: 24];
    end
  endgenerate

  assign xfer      = ov_reg & ordy;
  assign cnt_inc   = cnt_reg + 3'd1;
  assign head_conv = conv(head[23:0]);
  assign step_conv = conv(frame_ch[cnt_inc]);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    frame_next  = frame_reg;
    od_next     = od_reg;
    och_next    = och_reg;
    ov_next     = ov_reg;
    clip_next   = clip_reg;
    pop         = 1'b0;
    ovf_next    = ovf_reg | (iv & full);
    // A clipped sample counts once it is actually handed downstream.
    sat_next    = sat_reg | (xfer & clip_reg);
    wr_ptr_next = wr_ptr_reg + PW'(push);

    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          frame_next = head;
          {clip_next, od_next} = head_conv;
          och_next   = 3'd0;
          cnt_next   = 3'd0;
          ov_next    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (cnt_reg != 3'd7) begin
            cnt_next = cnt_inc;
            och_next = cnt_inc;
            {clip_next, od_next} = step_conv;
          end else if (!empty) begin
            // Chain straight into the next queued frame without a gap cycle.
            pop        = 1'b1;
            frame_next = head;
            {clip_next, od_next} = head_conv;
            och_next   = 3'd0;
            cnt_next   = 3'd0;
          end else begin
            ov_next    = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        ov_next    = 1'b0;
      end
    endcase

    rd_ptr_next = rd_ptr_reg + PW'(pop);
  end

  always_ff @(posedge c) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      frame_reg  <= '0;
      od_reg     <= 16'd0;
      och_reg    <= 3'd0;
      ov_reg     <= 1'b0;
      clip_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      frame_reg  <= frame_next;
      od_reg     <= od_next;
      och_reg    <= och_next;
      ov_reg     <= ov_next;
      clip_reg   <= clip_next;
      ovf_reg    <= ovf_next;
      sat_reg    <= sat_next;
    end
  end

  assign od  = od_reg;
  assign och = och_reg;
  assign ov  = ov_reg;
  assign ovf = ovf_reg;
  assign sat = sat_reg;

endmodule
